// File: rtl/adc_histogrammer_pipe.sv
// Per-channel ADC amplitude histogrammer.
// Pipelined RMW bin counters with forwarding, clear sweep and sample-limit stop.
module adc_histogrammer_pipe #(
   parameter int NCH   = 8,
   parameter int ADC_W = 12,
   parameter int BIN_W = 12,
   parameter int CNT_W = 32,
   parameter int CH_W  = 3
) (
   input  logic                   CLK,
   input  logic                   RSTb,
   input  logic [NCH*ADC_W-1:0]   ADC_DATA,
   input  logic                   ADC_VALID,
   input  logic [CH_W-1:0]        CH_SEL,
   input  logic                   ENABLE,
   input  logic                   CLEAR,
   input  logic [31:0]            SAMPLE_LIMIT,
   input  logic                   RD_EN,
   input  logic [BIN_W-1:0]       RD_ADDR,
   output logic [CNT_W-1:0]       RD_DATA,
   output logic                   RD_VALID,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   OVERFLOW,
   output logic [31:0]            SAMPLE_COUNT
);

   localparam int NBIN = 1 << BIN_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLR   = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [BIN_W-1:0] clr_addr_q, clr_addr_d;
   logic             drain_q, drain_d;
   logic             clr_pend_q, clr_pend_d;
   logic [31:0]      cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic             s1_vld_q, s1_vld_d;
   logic [BIN_W-1:0] s1_bin_q, s1_bin_d;
   logic             s1_fwd_q, s1_fwd_d;
   logic [CNT_W-1:0] s1_fval_q, s1_fval_d;
   logic             s2_vld_q, s2_vld_d;
   logic [BIN_W-1:0] s2_bin_q, s2_bin_d;
   logic [CNT_W-1:0] s2_val_q, s2_val_d;

   logic             rd_p1_q, rd_p1_d;
   logic             rd_vld_q, rd_vld_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   logic [CNT_W-1:0] ram_rd_q;
   logic [CNT_W-1:0] mem [0:NBIN-1];

   logic [ADC_W-1:0] smp;
   logic [BIN_W-1:0] bin;
   logic             limit_hit;
   logic             accept;
   logic [31:0]      cnt_nx;
   logic             hit_nx;
   logic [CNT_W-1:0] s1_base;
   logic [CNT_W-1:0] s1_new;
   logic             s1_hit;
   logic             s2_hit;
   logic             busy;
   logic             we;
   logic [BIN_W-1:0] waddr;
   logic [CNT_W-1:0] wdata;
   logic [BIN_W-1:0] raddr;

   // Pick the latched channel's sample out of the packed bus
   always_comb begin
      smp = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ch_q == CH_W'(k)) smp = ADC_DATA[k*ADC_W +: ADC_W];
      end
   end

   assign bin       = smp[ADC_W-1 -: BIN_W];
   assign busy      = (state_q == S_CLR) || (state_q == S_RUN) ||
                      (state_q == S_DRAIN);
   assign limit_hit = (SAMPLE_LIMIT != 32'd0) && (cnt_q >= SAMPLE_LIMIT);
   assign accept    = (state_q == S_RUN) && ENABLE && !CLEAR &&
                      ADC_VALID && !limit_hit;
   assign cnt_nx    = (accept && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
   assign hit_nx    = (SAMPLE_LIMIT != 32'd0) && (cnt_nx >= SAMPLE_LIMIT);
   assign s1_base   = s1_fwd_q ? s1_fval_q : ram_rd_q;
   assign s1_new    = (s1_base == CNT_MAX) ? CNT_MAX : s1_base + CNT_W'(1);
   assign s1_hit    = s1_vld_q && (s1_bin_q == bin);
   assign s2_hit    = s2_vld_q && (s2_bin_q == bin);

   // RAM port steering: clear sweep or S2 write, pipe or host read
   always_comb begin
      we    = s2_vld_q || (state_q == S_CLR);
      waddr = (state_q == S_CLR) ? clr_addr_q : s2_bin_q;
      wdata = (state_q == S_CLR) ? '0 : s2_val_q;
      raddr = (state_q == S_RUN) ? bin : RD_ADDR;
   end

   // Control FSM and sample accounting
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      clr_addr_d = clr_addr_q;
      drain_d    = drain_q;
      clr_pend_d = clr_pend_q;
      cnt_d      = cnt_nx;
      ovf_d      = ovf_q || (s1_vld_q && (s1_new == CNT_MAX));
      case (state_q)
         S_IDLE: begin
            if (CLEAR) begin
               state_d    = S_CLR;
               clr_addr_d = '0;
            end else if (ENABLE) begin
               state_d = S_RUN;
               ch_d    = CH_SEL;
            end
         end
         S_CLR: begin
            cnt_d      = '0;
            ovf_d      = 1'b0;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) state_d = S_IDLE;
         end
         S_RUN: begin
            if (CLEAR) begin
               state_d    = S_DRAIN;
               drain_d    = 1'b0;
               clr_pend_d = 1'b1;
            end else if (!ENABLE || hit_nx) begin
               state_d = S_DRAIN;
               drain_d = 1'b0;
            end
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (CLEAR) clr_pend_d = 1'b1;
            if (drain_q) begin
               if (clr_pend_q || CLEAR) begin
                  state_d    = S_CLR;
                  clr_addr_d = '0;
                  clr_pend_d = 1'b0;
               end else if (limit_hit) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DONE: begin
            if (CLEAR) begin
               state_d    = S_CLR;
               clr_addr_d = '0;
            end else if (!ENABLE) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Read-modify-write pipe with forwarding, plus host read return path
   always_comb begin
      s1_vld_d  = accept;
      s1_bin_d  = bin;
      s1_fwd_d  = accept && (s1_hit || s2_hit);
      s1_fval_d = s1_hit ? s1_new : s2_val_q;
      s2_vld_d  = s1_vld_q;
      s2_bin_d  = s1_bin_q;
      s2_val_d  = s1_new;
      rd_p1_d   = RD_EN && !busy;
      rd_vld_d  = rd_p1_q;
      rd_data_d = rd_p1_q ? ram_rd_q : rd_data_q;
   end

   // Bin RAM: registered read, single write port, no reset
   always_ff @(posedge CLK) begin
      ram_rd_q <= mem[raddr];
      if (we) mem[waddr] <= wdata;
   end

   // State registers
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         clr_addr_q <= '0;
         drain_q    <= 1'b0;
         clr_pend_q <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_bin_q   <= '0;
         s1_fwd_q   <= 1'b0;
         s1_fval_q  <= '0;
         s2_vld_q   <= 1'b0;
         s2_bin_q   <= '0;
         s2_val_q   <= '0;
         rd_p1_q    <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         clr_addr_q <= clr_addr_d;
         drain_q    <= drain_d;
         clr_pend_q <= clr_pend_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         s1_vld_q   <= s1_vld_d;
         s1_bin_q   <= s1_bin_d;
         s1_fwd_q   <= s1_fwd_d;
         s1_fval_q  <= s1_fval_d;
         s2_vld_q   <= s2_vld_d;
         s2_bin_q   <= s2_bin_d;
         s2_val_q   <= s2_val_d;
         rd_p1_q    <= rd_p1_d;
         rd_vld_q   <= rd_vld_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign RD_DATA      = rd_data_q;
   assign RD_VALID     = rd_vld_q;
   assign BUSY         = busy;
   assign DONE         = (state_q == S_DONE);
   assign OVERFLOW     = ovf_q;
   assign SAMPLE_COUNT = cnt_q;

endmodule

// File: tb/tb_adc_histogrammer_pipe.sv
// Bench for adc_histogrammer_pipe: directed table, corner sequences,
// randomized runs against a per-bin counting model.
module tb_adc_histogrammer_pipe;
   localparam int NCH   = 8;
   localparam int ADC_W = 12;
   localparam int BIN_W = 12;
   localparam int CH_W  = 3;
   localparam int NBIN  = 4096;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NCH*ADC_W-1:0] adc_data = '0;
   logic                 adc_valid = 1'b0;
   logic [CH_W-1:0]      ch_sel = '0;
   logic                 enable = 1'b0;
   logic                 clear = 1'b0;
   logic [31:0]          limit = '0;
   logic                 rd_en = 1'b0;
   logic [BIN_W-1:0]     rd_addr = '0;

   logic [31:0] rd_data, scount, scount4;
   logic [3:0]  rd_data4;
   logic rd_valid, busy, done, ovf;
   logic rd_valid4, busy4, done4, ovf4;

   adc_histogrammer_pipe u_dut (
      .CLK(clk), .RSTb(rst_n), .ADC_DATA(adc_data), .ADC_VALID(adc_valid),
      .CH_SEL(ch_sel), .ENABLE(enable), .CLEAR(clear),
      .SAMPLE_LIMIT(limit), .RD_EN(rd_en), .RD_ADDR(rd_addr),
      .RD_DATA(rd_data), .RD_VALID(rd_valid), .BUSY(busy), .DONE(done),
      .OVERFLOW(ovf), .SAMPLE_COUNT(scount));

   adc_histogrammer_pipe #(.CNT_W(4)) u_small (
      .CLK(clk), .RSTb(rst_n), .ADC_DATA(adc_data), .ADC_VALID(adc_valid),
      .CH_SEL(ch_sel), .ENABLE(enable), .CLEAR(clear),
      .SAMPLE_LIMIT(limit), .RD_EN(rd_en), .RD_ADDR(rd_addr),
      .RD_DATA(rd_data4), .RD_VALID(rd_valid4), .BUSY(busy4),
      .DONE(done4), .OVERFLOW(ovf4), .SAMPLE_COUNT(scount4));

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   int unsigned mdl [NBIN];
   int model_cnt = 0;
   int run_ch = 0;
   int run_lim = 0;

   typedef struct {
      int ch;
      int smp;
      int lim;
      int n;
      int exp_bin;
      bit exp_done;
      int exp_cnt;
   } vec_t;
   vec_t tbl [4];

   task automatic check(input string nm, input longint act, input longint exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint sat4(input longint x);
      return (x > 15) ? 15 : x;
   endfunction

   task automatic model_reset();
      foreach (mdl[i]) mdl[i] = 0;
      model_cnt = 0;
   endtask

   task automatic do_clear();
      int bc;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      bc = 0;
      while (busy && bc < 6000) begin
         bc++;
         tick();
      end
      check("clear_len", bc, 4096);
      model_reset();
   endtask

   task automatic read_bin(input int a, output longint v, output longint v4);
      adc_valid = 1'b0;
      rd_en = 1'b1;
      rd_addr = BIN_W'(a);
      tick();
      rd_en = 1'b0;
      tick();
      check($sformatf("rd_valid_%0d", a), rd_valid, 1);
      v  = rd_data;
      v4 = rd_data4;
      tick();
   endtask

   task automatic check_bin(input string nm, input int a);
      longint v, v4;
      read_bin(a, v, v4);
      check({nm, "_bin"}, v, mdl[a]);
      check({nm, "_bin4"}, v4, sat4(mdl[a]));
   endtask

   task automatic start_run(input int ch, input int lim);
      ch_sel = CH_W'(ch);
      limit = lim;
      enable = 1'b1;
      adc_valid = 1'b0;
      tick();
      run_ch = ch;
      run_lim = lim;
      ch_sel = CH_W'(ch + 1 + $urandom_range(0, 6));
   endtask

   task automatic stop_run();
      enable = 1'b0;
      adc_valid = 1'b0;
      repeat (4) tick();
      check("stop_idle", busy, 0);
   endtask

   task automatic strobe(input int smp, input bit vld);
      logic [NCH*ADC_W-1:0] d;
      for (int k = 0; k < NCH; k++) d[k*ADC_W +: ADC_W] = ADC_W'($urandom);
      d[run_ch*ADC_W +: ADC_W] = ADC_W'(smp);
      adc_data = d;
      adc_valid = vld;
      if (vld && (run_lim == 0 || model_cnt < run_lim)) begin
         mdl[smp % NBIN]++;
         model_cnt++;
      end
      tick();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      longint v, v4;
      int bc;
      bit saw_rv;
      int pool [6];
      int lim;
      bit any_ovf;

      tbl[0] = '{3, 'h7FF, 1000, 1100, 1000, 1'b1, 1000};
      tbl[1] = '{0, 'h000, 0,    50,   50,   1'b0, 50};
      tbl[2] = '{7, 'hFFF, 1,    10,   1,    1'b1, 1};
      tbl[3] = '{5, 'h123, 300,  200,  200,  1'b0, 200};

      model_reset();
      #22;
      check("rst_busy", busy, 0);
      check("rst_scount", scount, 0);
      rst_n = 1'b1;
      tick();
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_rdvalid", rd_valid, 0);
      check("rst_rddata", rd_data, 0);

      // CLEAR with ENABLE in IDLE must sweep, and reads are refused meanwhile
      clear = 1'b1;
      enable = 1'b1;
      tick();
      clear = 1'b0;
      enable = 1'b0;
      bc = 0;
      saw_rv = 1'b0;
      while (busy && bc < 6000) begin
         rd_en = (bc == 100);
         bc++;
         tick();
         if (rd_valid) saw_rv = 1'b1;
      end
      rd_en = 1'b0;
      check("clr_en_len", bc, 4096);
      check("rd_while_busy", saw_rv, 0);
      check_bin("clr0", 0);
      check_bin("clr2047", 2047);
      check_bin("clr4095", 4095);
      check("clr_ovf", ovf, 0);
      check("clr_scount", scount, 0);

      for (int i = 0; i < 4; i++) begin
         do_clear();
         start_run(tbl[i].ch, tbl[i].lim);
         for (int j = 0; j < tbl[i].n; j++) strobe(tbl[i].smp, 1'b1);
         adc_valid = 1'b0;
         repeat (4) tick();
         check($sformatf("t%0d_done", i), done, tbl[i].exp_done);
         check($sformatf("t%0d_count", i), scount, tbl[i].exp_cnt);
         stop_run();
         read_bin(tbl[i].smp, v, v4);
         check($sformatf("t%0d_bin", i), v, tbl[i].exp_bin);
         if (tbl[i].smp > 0) begin
            read_bin(tbl[i].smp - 1, v, v4);
            check($sformatf("t%0d_lo", i), v, 0);
         end
         if (tbl[i].smp < NBIN - 1) begin
            read_bin(tbl[i].smp + 1, v, v4);
            check($sformatf("t%0d_hi", i), v, 0);
         end
      end

      // Alternating neighbouring bins
      do_clear();
      start_run(1, 0);
      for (int i = 0; i < 100; i++) strobe((i % 2) ? 2 : 1, 1'b1);
      stop_run();
      read_bin(1, v, v4);
      check("alt_bin1", v, 50);
      read_bin(2, v, v4);
      check("alt_bin2", v, 50);
      check("alt_count", scount, 100);

      // Saturation on the narrow-counter instance
      do_clear();
      start_run(2, 0);
      for (int i = 0; i < 20; i++) strobe(5, 1'b1);
      stop_run();
      read_bin(5, v, v4);
      check("sat_bin32", v, 20);
      check("sat_bin4", v4, 15);
      check("sat_ovf4", ovf4, 1);
      check("sat_ovf32", ovf, 0);
      check("sat_count4", scount4, 20);

      // ENABLE dropped behind a same-bin burst still in the pipe
      start_run(4, 0);
      for (int i = 0; i < 3; i++) strobe('h0AA, 1'b1);
      enable = 1'b0;
      adc_data[run_ch*ADC_W +: ADC_W] = 12'h0AA;
      adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
      check("drain_c1", busy, 1);
      tick();
      check("drain_c2", busy, 1);
      tick();
      check("drain_idle", busy, 0);
      read_bin('h0AA, v, v4);
      check("burst_bin", v, 3);
      check("burst_count", scount, 23);

      // Random run over a small bin pool, unlimited
      do_clear();
      for (int i = 0; i < 6; i++) pool[i] = $urandom_range(0, NBIN - 1);
      start_run($urandom_range(0, NCH - 1), 0);
      for (int i = 0; i < 400; i++)
         strobe(pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
      stop_run();
      any_ovf = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check_bin($sformatf("rnd_p%0d", i), pool[i]);
         if (mdl[pool[i]] >= 15) any_ovf = 1'b1;
      end
      check("rnd_count", scount, model_cnt);
      check("rnd_ovf4", ovf4, any_ovf);
      check("rnd_ovf32", ovf, 0);

      // Random run with a sample limit
      do_clear();
      lim = $urandom_range(40, 100);
      start_run($urandom_range(0, NCH - 1), lim);
      for (int i = 0; i < 300; i++)
         strobe(pool[$urandom_range(0, 5)], 1'($urandom_range(0, 3) != 0));
      adc_valid = 1'b0;
      repeat (4) tick();
      check("lim_done", done, model_cnt >= lim);
      check("lim_count", scount, model_cnt);
      stop_run();
      for (int i = 0; i < 6; i++) check_bin($sformatf("lim_p%0d", i), pool[i]);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
